// File: rtl/multiport_register_file_pkg.sv
// Shared types for the multiport register file: default-build word/address types and the
// hardwired-zero register index.
package multiport_register_file_pkg;

    localparam int DEFAULT_REG_COUNT  = 32;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_AW         = $clog2(DEFAULT_REG_COUNT);

    // Register 0 always reads as zero, is never stored and is never busy.
    localparam int ZERO_REG = 0;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] Word;
    typedef logic [DEFAULT_AW-1:0]         RegAddress;

endpackage

// File: rtl/multiport_register_file_scoreboard.sv
// Per-register busy scoreboard for the hazard unit: reserve beats flush, flush beats
// writeback clear. busy_any_o is the OR of the registered busy bits.
module rf_scoreboard
    import multiport_register_file_pkg::*;
#(
    parameter int REG_COUNT = DEFAULT_REG_COUNT,
    parameter int NUM_WRITE = 1,
    localparam int AW = $clog2(REG_COUNT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_WRITE-1:0]    wr_en_i,
    input  logic [NUM_WRITE*AW-1:0] wr_addr_i,
    input  logic                    rsv_en_i,
    input  logic [AW-1:0]           rsv_addr_i,
    input  logic                    flush_i,
    output logic [REG_COUNT-1:0]    busy_o,
    output logic                    busy_any_o
);

    logic [REG_COUNT-1:0] busy_q;
    logic [REG_COUNT-1:0] busy_d;
    logic [REG_COUNT-1:0] wrHit;

    always_comb begin
        wrHit = '0;
        for (int w = 0; w < NUM_WRITE; w++) begin
            if (wr_en_i[w]) begin
                wrHit[wr_addr_i[w*AW +: AW]] = 1'b1;
            end
        end
    end

    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < REG_COUNT; r++) begin
            if (rsv_en_i && rsv_addr_i == AW'(r)) begin
                busy_d[r] = 1'b1;
            end else if (flush_i) begin
                busy_d[r] = 1'b0;
            end else if (wrHit[r]) begin
                busy_d[r] = 1'b0;
            end
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_any_o = |busy_q;

endmodule

// File: rtl/multiport_register_file.sv
// Parametrised register file with N read / M write ports, optional same-cycle write-to-read
// bypass and a busy scoreboard. Register 0 is hardwired to zero.
module multiport_register_file
    import multiport_register_file_pkg::*;
#(
    parameter int REG_COUNT  = DEFAULT_REG_COUNT,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 1,
    parameter bit BYPASS     = 1'b1,
    localparam int AW = $clog2(REG_COUNT)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_WRITE-1:0]            wr_en,
    input  logic [NUM_WRITE*AW-1:0]         wr_addr,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_READ*AW-1:0]          rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0]  rd_data,
    output logic [NUM_READ-1:0]             rd_busy,
    input  logic                            rsv_en,
    input  logic [AW-1:0]                   rsv_addr,
    input  logic                            flush,
    output logic                            busy_any
);

    logic [DATA_WIDTH-1:0] regs_q [1:REG_COUNT-1];
    logic [DATA_WIDTH-1:0] regs_d [1:REG_COUNT-1];
    logic [REG_COUNT-1:0]  busy;

    // Ports are visited in ascending order so the highest-index port wins an address clash.
    always_comb begin
        regs_d = regs_q;
        for (int w = 0; w < NUM_WRITE; w++) begin
            if (wr_en[w] && wr_addr[w*AW +: AW] != AW'(ZERO_REG)) begin
                regs_d[wr_addr[w*AW +: AW]] = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    rf_scoreboard #(
        .REG_COUNT (REG_COUNT),
        .NUM_WRITE (NUM_WRITE)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .rsv_en_i   (rsv_en),
        .rsv_addr_i (rsv_addr),
        .flush_i    (flush),
        .busy_o     (busy),
        .busy_any_o (busy_any)
    );

    for (genvar p = 0; p < NUM_READ; p++) begin : g_read
        logic [AW-1:0]         addr;
        logic [DATA_WIDTH-1:0] portData;
        logic                  portBusy;
        logic                  fwdHit;

        assign addr = rd_addr[p*AW +: AW];

        // Forwarding also clears the busy view; reset forces the port quiet even when bypassing.
        always_comb begin
            portData = '0;
            fwdHit   = 1'b0;
            if (addr != AW'(ZERO_REG)) begin
                portData = regs_q[addr];
                if (BYPASS) begin
                    for (int w = 0; w < NUM_WRITE; w++) begin
                        if (wr_en[w] && wr_addr[w*AW +: AW] == addr) begin
                            portData = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
                            fwdHit   = 1'b1;
                        end
                    end
                end
            end
            portBusy = busy[addr] & ~fwdHit;
            if (!rst_n) begin
                portData = '0;
                portBusy = 1'b0;
            end
        end

        assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = portData;
        assign rd_busy[p]                          = portBusy;
    end

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed plus random checks of two register-file builds (bypass on/off, two write ports)
// against an array-based reference model.
module tb_multiport_register_file;
    import multiport_register_file_pkg::*;

    localparam int RC = 32;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic [NW-1:0]    wrEn;
    logic [NW*AW-1:0] wrAddr;
    logic [NW*DW-1:0] wrData;
    logic [NR*AW-1:0] rdAddr;
    logic             rsvEn;
    logic [AW-1:0]    rsvAddr;
    logic             flush;
    logic [NR*DW-1:0] rdDataB;
    logic [NR*DW-1:0] rdDataN;
    logic [NR-1:0]    rdBusyB;
    logic [NR-1:0]    rdBusyN;
    logic             busyAnyB;
    logic             busyAnyN;

    Word modelReg [RC];
    bit  modelBusy [RC];
    int  evaluated = 0;
    int  failures  = 0;

    always #5 clk = ~clk;

    multiport_register_file #(
        .REG_COUNT(RC), .DATA_WIDTH(DW), .NUM_READ(NR), .NUM_WRITE(NW), .BYPASS(1'b1)
    ) dutB (
        .clk(clk), .rst_n(rst_n), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .rd_addr(rdAddr), .rd_data(rdDataB), .rd_busy(rdBusyB), .rsv_en(rsvEn),
        .rsv_addr(rsvAddr), .flush(flush), .busy_any(busyAnyB)
    );

    multiport_register_file #(
        .REG_COUNT(RC), .DATA_WIDTH(DW), .NUM_READ(NR), .NUM_WRITE(NW), .BYPASS(1'b0)
    ) dutN (
        .clk(clk), .rst_n(rst_n), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .rd_addr(rdAddr), .rd_data(rdDataN), .rd_busy(rdBusyN), .rsv_en(rsvEn),
        .rsv_addr(rsvAddr), .flush(flush), .busy_any(busyAnyN)
    );

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        evaluated++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < RC; i++) begin
            modelReg[i]  = '0;
            modelBusy[i] = 1'b0;
        end
    endtask

    task automatic idle();
        wrEn    = '0;
        wrAddr  = '0;
        wrData  = '0;
        rsvEn   = 1'b0;
        rsvAddr = '0;
        flush   = 1'b0;
    endtask

    task automatic setWrite(input int p, input int a, input Word d);
        wrEn[p]            = 1'b1;
        wrAddr[p*AW +: AW] = AW'(a);
        wrData[p*DW +: DW] = d;
    endtask

    task automatic setRead(input int p, input int a);
        rdAddr[p*AW +: AW] = AW'(a);
    endtask

    // Newest write in the cycle is the highest enabled port aimed at the address.
    function automatic int youngestWriter(input int a);
        for (int w = NW - 1; w >= 0; w--) begin
            if (wrEn[w] && int'(wrAddr[w*AW +: AW]) == a) return w;
        end
        return -1;
    endfunction

    function automatic Word expRead(input bit bypass, input int a);
        int w;
        if (a == 0) return '0;
        w = youngestWriter(a);
        if (bypass && w >= 0) return wrData[w*DW +: DW];
        return modelReg[a];
    endfunction

    function automatic bit expBusy(input bit bypass, input int a);
        if (a == 0) return 1'b0;
        if (bypass && youngestWriter(a) >= 0) return 1'b0;
        return modelBusy[a];
    endfunction

    function automatic bit expBusyAny();
        for (int i = 0; i < RC; i++) begin
            if (modelBusy[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic checkOutput(input string tag);
        int a;
        for (int p = 0; p < NR; p++) begin
            a = int'(rdAddr[p*AW +: AW]);
            checkValue($sformatf("%s.B.data%0d", tag, p), rdDataB[p*DW +: DW], expRead(1'b1, a));
            checkValue($sformatf("%s.N.data%0d", tag, p), rdDataN[p*DW +: DW], expRead(1'b0, a));
            checkValue($sformatf("%s.B.busy%0d", tag, p), 32'(rdBusyB[p]), 32'(expBusy(1'b1, a)));
            checkValue($sformatf("%s.N.busy%0d", tag, p), 32'(rdBusyN[p]), 32'(expBusy(1'b0, a)));
        end
        checkValue({tag, ".B.busyAny"}, 32'(busyAnyB), 32'(expBusyAny()));
        checkValue({tag, ".N.busyAny"}, 32'(busyAnyN), 32'(expBusyAny()));
    endtask

    task automatic commitModel();
        bit written [RC];
        for (int i = 0; i < RC; i++) written[i] = 1'b0;
        for (int w = 0; w < NW; w++) begin
            if (wrEn[w]) begin
                written[int'(wrAddr[w*AW +: AW])] = 1'b1;
                if (wrAddr[w*AW +: AW] != 0) modelReg[int'(wrAddr[w*AW +: AW])] = wrData[w*DW +: DW];
            end
        end
        for (int r = 1; r < RC; r++) begin
            if (rsvEn && int'(rsvAddr) == r) modelBusy[r] = 1'b1;
            else if (flush)                  modelBusy[r] = 1'b0;
            else if (written[r])             modelBusy[r] = 1'b0;
        end
    endtask

    // Called at a negedge with inputs set: check combinational outputs, cross the edge, return at next negedge.
    task automatic applyStimulus(input string tag);
        #2;
        checkOutput(tag);
        @(posedge clk);
        commitModel();
        @(negedge clk);
    endtask

    task automatic dumpRegs(output int lines);
        Word v;
        lines = 0;
        $display("REGS:");
        for (int i = 0; i < RC; i++) begin
            @(negedge clk);
            setRead(0, i);
            #1;
            v = rdDataN[DW-1:0];
            if (!$isunknown(v) && v != 0) begin
                $display("  r%0d: %0d", i, v);
                lines++;
            end
        end
    endtask

    initial begin
        int lines;
        rst_n  = 1'b0;
        rdAddr = '0;
        idle();
        clearModel();
        repeat (2) @(negedge clk);
        checkOutput("reset");
        rst_n = 1'b1;

        // Asynchronous reset between edges wipes data and busy immediately.
        @(negedge clk);
        setWrite(0, 5, 77);
        rsvEn = 1'b1; rsvAddr = 5'd6;
        applyStimulus("rst.w5");
        idle();
        setRead(0, 5);
        #2;
        checkValue("rst.pre.r5", rdDataN[DW-1:0], 77);
        checkValue("rst.pre.busyAny", 32'(busyAnyN), 1);
        #1 rst_n = 1'b0;
        #1;
        checkValue("rst.B.r5", rdDataB[DW-1:0], 0);
        checkValue("rst.N.r5", rdDataN[DW-1:0], 0);
        checkValue("rst.busyAny", 32'(busyAnyB), 0);
        clearModel();
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < RC; i += 2) begin
            idle();
            setWrite(0, i, Word'(10 * i + 1));
            setWrite(1, i + 1, Word'(10 * (i + 1) + 1));
            applyStimulus("fill");
        end
        idle();
        setRead(0, 0); setRead(1, 10);
        #2;
        checkValue("fill.r0", rdDataN[DW-1:0], 0);
        checkValue("fill.r10", rdDataN[DW +: DW], 101);
        setRead(1, 11);
        #1 checkValue("fill.r11", rdDataB[DW +: DW], 111);
        dumpRegs(lines);
        checkValue("dump.lines", 32'(lines), 31);

        @(negedge clk);
        setWrite(0, 3, 4);
        applyStimulus("byp.w4");
        idle();
        setWrite(0, 3, 9);
        setRead(0, 3);
        #2;
        checkValue("byp.B.before", rdDataB[DW-1:0], 9);
        checkValue("byp.N.before", rdDataN[DW-1:0], 4);
        applyStimulus("byp.w9");
        idle();
        #2 checkValue("byp.N.after", rdDataN[DW-1:0], 9);

        @(negedge clk);
        setWrite(0, 7, 1);
        setWrite(1, 7, 2);
        applyStimulus("dual");
        idle();
        setRead(0, 7);
        #2;
        checkValue("dual.B.r7", rdDataB[DW-1:0], 2);
        checkValue("dual.N.r7", rdDataN[DW-1:0], 2);

        @(negedge clk);
        rsvEn = 1'b1; rsvAddr = 5'd4;
        setRead(0, 4);
        applyStimulus("sb.rsv");
        idle();
        #2;
        checkValue("sb.B.busyNext", 32'(rdBusyB[0]), 1);
        checkValue("sb.N.busyNext", 32'(rdBusyN[0]), 1);
        @(negedge clk);
        setWrite(0, 4, 6);
        #2;
        checkValue("sb.B.wbSameCycle", 32'(rdBusyB[0]), 0);
        checkValue("sb.N.wbSameCycle", 32'(rdBusyN[0]), 1);
        applyStimulus("sb.wb");
        idle();
        checkOutput("sb.afterWb");
        rsvEn = 1'b1; rsvAddr = 5'd4;
        setWrite(0, 4, 8);
        applyStimulus("sb.rsvwr");
        idle();
        #2 checkValue("sb.rsvwr.busy", 32'(rdBusyN[0]), 1);

        @(negedge clk);
        rsvEn = 1'b1; rsvAddr = 5'd2;
        applyStimulus("fl.rsv2");
        rsvAddr = 5'd9;
        applyStimulus("fl.rsv9");
        flush = 1'b1;
        applyStimulus("fl.flush");
        idle();
        setRead(0, 2); setRead(1, 9);
        #2;
        checkValue("fl.r2", 32'(rdBusyB[0]), 0);
        checkValue("fl.r9", 32'(rdBusyB[1]), 1);
        checkValue("fl.busyAny", 32'(busyAnyN), 1);

        @(negedge clk);
        for (int i = 0; i < 400; i++) begin
            idle();
            for (int w = 0; w < NW; w++) begin
                if ($urandom_range(0, 1) == 1) setWrite(w, int'($urandom_range(0, RC - 1)), Word'($urandom()));
            end
            for (int p = 0; p < NR; p++) begin
                if ($urandom_range(0, 2) == 0) rdAddr[p*AW +: AW] = wrAddr[($urandom_range(0, NW - 1))*AW +: AW];
                else setRead(p, int'($urandom_range(0, RC - 1)));
            end
            rsvEn   = ($urandom_range(0, 2) == 0);
            rsvAddr = AW'($urandom_range(0, RC - 1));
            flush   = ($urandom_range(0, 15) == 0);
            if (i == 200) begin
                // Reset held across an edge with live writes: everything reads zero, the write is lost.
                #1 rst_n = 1'b0;
                #1;
                checkValue("rand.rst.B.data0", rdDataB[DW-1:0], 0);
                checkValue("rand.rst.B.busy0", 32'(rdBusyB[0]), 0);
                checkValue("rand.rst.N.busyAny", 32'(busyAnyN), 0);
                @(negedge clk);
                clearModel();
                rst_n = 1'b1;
            end else begin
                applyStimulus("rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
        $finish;
    end

endmodule
